// File: rtl/dcache_axi_bridge_pkg.sv
// rtl/dcache_axi_bridge_pkg.sv - shared line geometry, AXI encodings and FSM state type
package dcache_axi_bridge_pkg;

    localparam int LINE_W_DEF = 128;
    localparam int OFFSET_W   = 4;
    localparam int AXI_ID_W   = 4;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WB_RD,
        S_WB_CAP,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_FILL,
        S_DONE
    } state_t;

    // Clears the byte offset so every bus address is line aligned.
    function automatic logic [63:0] line_align(input logic [63:0] addr);
        return {addr[63:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_axi_bridge_if.sv
// rtl/dcache_axi_bridge_if.sv - AXI4 master bus between the dcache bridge and memory
// master: drives aw*/w*/ar* payload and valids, bready, rready
// slave : drives awready, wready, b*, arready, r*
interface dcache_axi_bridge_if #(
    parameter int AXI_DW = 64
);
    import dcache_axi_bridge_pkg::*;

    logic [AXI_ID_W-1:0] awid;
    logic [63:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [AXI_DW-1:0]   wdata;
    logic [AXI_DW/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [AXI_ID_W-1:0] arid;
    logic [63:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [AXI_DW-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/dcache_axi_bridge.sv
// rtl/dcache_axi_bridge.sv - dcache miss engine: optional victim writeback burst, then refill burst
// clk, rst (async, active low)
// miss_req/miss_addr/miss_dirty/wb_addr : miss start from the cache controller
// write_back/cacheline_old             : victim read strobe and the line returned one cycle later
// refresh/cacheline_new                : one-cycle line-write strobe and the refill line
// miss_done/miss_err                   : completion pulse and sticky error flag
// axi                                  : AXI4 master bus (2-beat INCR bursts)
module dcache_axi_bridge
    import dcache_axi_bridge_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int AXI_DW = 64,
    parameter int AXI_ID = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_req,
    input  logic [63:0]         miss_addr,
    input  logic                miss_dirty,
    input  logic [63:0]         wb_addr,
    output logic                write_back,
    input  logic [LINE_W-1:0]   cacheline_old,
    output logic                refresh,
    output logic [LINE_W-1:0]   cacheline_new,
    output logic                miss_done,
    output logic                miss_err,
    dcache_axi_bridge_if.master axi
);

    localparam int BEATS = LINE_W / AXI_DW;

    state_t            state, state_n;
    logic [63:0]       refill_addr;
    logic [63:0]       victim_addr;
    logic [LINE_W-1:0] victim_line;
    logic [LINE_W-1:0] refill_line;
    logic              beat;
    logic              r_full;     // both refill beats stored; later beats are dropped
    logic              aw_valid, w_valid, b_ready, ar_valid, r_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        write_back = 1'b0;
        refresh    = 1'b0;
        miss_done  = 1'b0;
        aw_valid   = 1'b0;
        w_valid    = 1'b0;
        b_ready    = 1'b0;
        ar_valid   = 1'b0;
        r_ready    = 1'b0;
        case (state)
            S_IDLE:   if (miss_req) state_n = miss_dirty ? S_WB_RD : S_AR;
            S_WB_RD:  begin write_back = 1'b1; state_n = S_WB_CAP; end
            // The data array answers the strobe one cycle later; capture happens here.
            S_WB_CAP: state_n = S_AW;
            S_AW:     begin aw_valid = 1'b1; if (axi.awready) state_n = S_W; end
            S_W:      begin w_valid = 1'b1; if (axi.wready && beat) state_n = S_B; end
            S_B:      begin b_ready = 1'b1; if (axi.bvalid) state_n = S_AR; end
            S_AR:     begin ar_valid = 1'b1; if (axi.arready) state_n = S_R; end
            S_R:      begin r_ready = 1'b1; if (axi.rvalid && axi.rlast) state_n = S_FILL; end
            S_FILL:   begin refresh = 1'b1; state_n = S_DONE; end
            S_DONE:   begin miss_done = 1'b1; state_n = S_IDLE; end
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refill_addr <= '0;
            victim_addr <= '0;
            victim_line <= '0;
            refill_line <= '0;
            beat        <= 1'b0;
            r_full      <= 1'b0;
            miss_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_req) begin
                        refill_addr <= line_align(miss_addr);
                        victim_addr <= line_align(wb_addr);
                        miss_err    <= 1'b0;
                        beat        <= 1'b0;
                        r_full      <= 1'b0;
                    end
                end
                S_WB_CAP: victim_line <= cacheline_old;
                // Two accepted beats wrap the counter back to 0, ready for the refill.
                S_W: if (axi.wready) beat <= ~beat;
                S_B: if (axi.bvalid && axi.bresp != AXI_RESP_OKAY) miss_err <= 1'b1;
                S_R: begin
                    if (axi.rvalid && !r_full) begin
                        if (!beat) begin
                            // Upper half zeroed so a burst cut short by rlast leaves no stale data.
                            refill_line <= LINE_W'(axi.rdata);
                            beat        <= 1'b1;
                            if (axi.rlast || axi.rresp != AXI_RESP_OKAY) miss_err <= 1'b1;
                        end else begin
                            refill_line[AXI_DW +: AXI_DW] <= axi.rdata;
                            beat        <= 1'b0;
                            r_full      <= 1'b1;
                            if (axi.rresp != AXI_RESP_OKAY) miss_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cacheline_new = refill_line;

    assign axi.awid    = AXI_ID_W'(AXI_ID);
    assign axi.awaddr  = victim_addr;
    assign axi.awlen   = 8'(BEATS - 1);
    assign axi.awsize  = AXI_SIZE_8B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awvalid = aw_valid;

    assign axi.wdata   = beat ? victim_line[AXI_DW +: AXI_DW] : victim_line[AXI_DW-1:0];
    assign axi.wstrb   = '1;
    assign axi.wlast   = beat;
    assign axi.wvalid  = w_valid;

    assign axi.bready  = b_ready;

    assign axi.arid    = AXI_ID_W'(AXI_ID);
    assign axi.araddr  = refill_addr;
    assign axi.arlen   = 8'(BEATS - 1);
    assign axi.arsize  = AXI_SIZE_8B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = ar_valid;

    assign axi.rready  = r_ready;

endmodule
